// File: rtl/banked_main_mem_if.sv
// Request/response bus between the cache controller and banked_main_mem.
// Handshake: a request is presented by holding rd or wr (never both) with
// addr/data_in stable; it is taken in the first cycle where stall is low.
// While stall is high the requester must keep addr/rd/wr unchanged. Read
// data returns on data_out a fixed latency after acceptance, in accept order.
interface banked_main_mem_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, stall, busy, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, stall, busy, err
    );
endinterface

// File: rtl/banked_main_mem.sv
// Four-bank word-interleaved main memory. bank = addr[2:1], row = addr[15:3].
// Each bank stays occupied for BANK_CYCLES after an access; reads return
// after READ_LAT cycles through a valid/data shift register.
// Optional feature: define BANKED_MEM_ALIGN_CHECK_EN to flag odd addresses
// as illegal requests (err) instead of silently ignoring addr[0].
module banked_main_mem #(
    parameter int ROWS        = 8192,
    parameter int BANK_CYCLES = 4,
    parameter int READ_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    banked_main_mem_if.slave  bus
);
    localparam int CNT_W = $clog2(BANK_CYCLES);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [1:0]       bank;
    logic [ROW_W-1:0] row;
    logic             align_bad;
    logic             illegal;
    logic             single;
    logic             accept;
    logic             rd_accept;
    logic             wr_accept;
    logic [3:0]       busy_w;
    logic [15:0]      rd_word;

    logic [CNT_W-1:0] cnt [4];
    logic [15:0]      mem [4][ROWS];
    logic [READ_LAT-1:0] pipe_valid;
    logic [15:0]         pipe_data [READ_LAT];
    logic                err_q;

    assign bank = bus.addr[2:1];
    // Rows beyond ROWS alias back into the array.
    assign row  = ROW_W'(32'(bus.addr[15:3]) % 32'(ROWS));

`ifdef BANKED_MEM_ALIGN_CHECK_EN
    assign align_bad = (bus.rd | bus.wr) & bus.addr[0];
`else
    logic unused_addr0;
    assign unused_addr0 = bus.addr[0];
    assign align_bad    = 1'b0;
`endif

    // A request with both strobes or a bad alignment is never accepted nor stalled.
    assign single    = bus.rd ^ bus.wr;
    assign illegal   = (bus.rd & bus.wr) | align_bad;
    assign accept    = single & ~busy_w[bank] & ~align_bad;
    assign rd_accept = accept & bus.rd;
    assign wr_accept = accept & bus.wr;
    assign bus.stall = single & busy_w[bank] & ~align_bad;
    assign rd_word   = mem[bank][row];

    // Bank occupancy flags derived from the per-bank down-counters.
    always_comb begin
        busy_w = '0;
        for (int b = 0; b < 4; b++) begin
            busy_w[b] = (cnt[b] != '0);
        end
    end
    assign bus.busy = busy_w;

    // Per-bank occupancy counters: load on accept, otherwise count down to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && (bank == 2'(b))) begin
                    cnt[b] <= CNT_W'(BANK_CYCLES - 1);
                end else if (cnt[b] != '0) begin
                    cnt[b] <= cnt[b] - 1'b1;
                end
            end
        end
    end

    // Storage array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[bank][row] <= bus.data_in;
        end
    end

    // Read return pipeline; reset drops any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            if (rd_accept) begin
                pipe_data[0] <= rd_word;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign bus.data_out = pipe_valid[READ_LAT-1] ? pipe_data[READ_LAT-1] : 16'h0000;

    // Error flag follows an illegal request by exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= illegal;
        end
    end
    assign bus.err = err_q;

endmodule
